axil_reg_bridge: RTL and testbench

// AXI4-lite slave that terminates the m_axil side of an AXI-lite register slice and drives a simple

---
 rtl/axil_reg_bridge.sv | 224 ++++++++++++++++++++++
 tb/tb_axil_reg_bridge.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_bridge.sv
`default_nettype none
// ============================================================================
// axil_reg_bridge : AXI4-lite slave to single-strobe CSR bus with ack timeout
// Revision 1.0
// ============================================================================
module axil_reg_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic [STRB_WIDTH-1:0] reg_wr_strb,
  output logic                  reg_wr_en,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  input  logic                  reg_ack
);

  localparam int                c_CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [1:0]        c_OKAY     = 2'b00;
  localparam logic [1:0]        c_SLVERR   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_WAIT = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR_RESP = 3'd3,
    S_RD_RESP = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_aw_held;
  logic                  r_w_held;
  logic                  r_prio_rd;
  logic [ADDR_WIDTH-1:0] r_aw_addr;
  logic [DATA_WIDTH-1:0] r_w_data;
  logic [STRB_WIDTH-1:0] r_w_strb;
  logic [c_CNT_W-1:0]    r_cnt;
  logic [1:0]            r_bresp;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [ADDR_WIDTH-1:0] r_reg_addr;
  logic [DATA_WIDTH-1:0] r_reg_wr_data;
  logic [STRB_WIDTH-1:0] r_reg_wr_strb;
  logic                  r_reg_wr_en;
  logic                  r_reg_rd_en;

  logic w_awready;
  logic w_wready;
  logic w_arready;
  logic w_contend;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_ar_hs;
  logic w_start_wr;
  logic w_tmo;
  logic w_unused;

  assign w_unused = ^{s_axil_awprot, s_axil_arprot};

  // Contention only matters before either side has started a handshake.
  assign w_contend = s_axil_arvalid && (s_axil_awvalid || s_axil_wvalid) && !r_aw_held && !r_w_held;

  always_comb begin
    w_awready = 1'b0;
    w_wready  = 1'b0;
    w_arready = 1'b0;
    if (r_state == S_IDLE && !rst) begin
      w_awready = !r_aw_held && !(w_contend && r_prio_rd);
      w_wready  = !r_w_held && !(w_contend && r_prio_rd);
      w_arready = !r_aw_held && !r_w_held && !(w_contend && !r_prio_rd);
    end
  end

  assign w_aw_hs    = s_axil_awvalid && w_awready;
  assign w_w_hs     = s_axil_wvalid && w_wready;
  assign w_ar_hs    = s_axil_arvalid && w_arready;
  assign w_start_wr = (r_state == S_IDLE) && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

  generate
    if (TIMEOUT > 0) begin : g_tmo
      assign w_tmo = (r_cnt == c_TMO_LAST);
    end else begin : g_no_tmo
      assign w_tmo = 1'b0;
    end
  endgenerate

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_ar_hs) begin
          w_next = S_RD_WAIT;
        end else if (w_start_wr) begin
          w_next = S_WR_WAIT;
        end
      end
      S_WR_WAIT: if (reg_ack || w_tmo) w_next = S_WR_RESP;
      S_RD_WAIT: if (reg_ack || w_tmo) w_next = S_RD_RESP;
      S_WR_RESP: if (s_axil_bready) w_next = S_IDLE;
      S_RD_RESP: if (s_axil_rready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_aw_held     <= 1'b0;
      r_w_held      <= 1'b0;
      r_prio_rd     <= 1'b1;
      r_aw_addr     <= '0;
      r_w_data      <= '0;
      r_w_strb      <= '0;
      r_cnt         <= '0;
      r_bresp       <= c_OKAY;
      r_rresp       <= c_OKAY;
      r_rdata       <= '0;
      r_reg_addr    <= '0;
      r_reg_wr_data <= '0;
      r_reg_wr_strb <= '0;
      r_reg_wr_en   <= 1'b0;
      r_reg_rd_en   <= 1'b0;
    end else begin
      r_reg_wr_en <= w_start_wr;
      r_reg_rd_en <= w_ar_hs;

      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_aw_addr <= s_axil_awaddr;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_w_data <= s_axil_wdata;
        r_w_strb <= s_axil_wstrb;
      end

      // Each grant hands priority to the other direction.
      if (w_start_wr) begin
        r_aw_held     <= 1'b0;
        r_w_held      <= 1'b0;
        r_prio_rd     <= 1'b1;
        r_cnt         <= '0;
        r_reg_addr    <= r_aw_held ? r_aw_addr : s_axil_awaddr;
        r_reg_wr_data <= r_w_held ? r_w_data : s_axil_wdata;
        r_reg_wr_strb <= r_w_held ? r_w_strb : s_axil_wstrb;
      end else if (w_ar_hs) begin
        r_prio_rd  <= 1'b0;
        r_cnt      <= '0;
        r_reg_addr <= s_axil_araddr;
      end

      if (r_state == S_WR_WAIT || r_state == S_RD_WAIT) begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end

      if (r_state == S_WR_WAIT) begin
        if (reg_ack) begin
          r_bresp <= c_OKAY;
        end else if (w_tmo) begin
          r_bresp <= c_SLVERR;
        end
      end

      if (r_state == S_RD_WAIT) begin
        if (reg_ack) begin
          r_rresp <= c_OKAY;
          r_rdata <= reg_rd_data;
        end else if (w_tmo) begin
          r_rresp <= c_SLVERR;
          r_rdata <= '0;
        end
      end
    end
  end

  assign s_axil_awready = w_awready;
  assign s_axil_wready  = w_wready;
  assign s_axil_arready = w_arready;
  assign s_axil_bvalid  = (r_state == S_WR_RESP);
  assign s_axil_bresp   = r_bresp;
  assign s_axil_rvalid  = (r_state == S_RD_RESP);
  assign s_axil_rresp   = r_rresp;
  assign s_axil_rdata   = r_rdata;
  assign reg_addr       = r_reg_addr;
  assign reg_wr_data    = r_reg_wr_data;
  assign reg_wr_strb    = r_reg_wr_strb;
  assign reg_wr_en      = r_reg_wr_en;
  assign reg_rd_en      = r_reg_rd_en;

endmodule
`default_nettype wire

// File: tb/tb_axil_reg_bridge.sv
`default_nettype none
// ============================================================================
// tb_axil_reg_bridge : directed self-checking bench for axil_reg_bridge
// Revision 1.0
// ============================================================================
module tb_axil_reg_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] reg_addr;
  logic [31:0] reg_wr_data;
  logic [3:0]  reg_wr_strb;
  logic        reg_wr_en;
  logic        reg_rd_en;
  logic [31:0] reg_rd_data;
  logic        reg_ack;

  int n_chk  = 0;
  int n_fail = 0;
  int n_wr_pulse = 0;
  int wr0;

  always #5 clk = ~clk;

  always @(posedge clk) if (reg_wr_en) n_wr_pulse <= n_wr_pulse + 1;

  axil_reg_bridge #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .STRB_WIDTH(4), .TIMEOUT(16)
  ) u_dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .reg_addr(reg_addr), .reg_wr_data(reg_wr_data), .reg_wr_strb(reg_wr_strb),
    .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data), .reg_ack(reg_ack)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic arb_round(input int idx, input bit exp_rd);
    step();
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    awaddr = 32'h100 + 32'(idx * 4); araddr = 32'h200 + 32'(idx * 4);
    wdata = 32'(idx); wstrb = 4'hF; reg_rd_data = 32'hA0 + 32'(idx);
    mid();
    check($sformatf("arb%0d_arready", idx), arready, exp_rd);
    check($sformatf("arb%0d_awready", idx), awready, !exp_rd);
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; reg_ack = 1'b1;
    mid();
    if (exp_rd) begin
      check($sformatf("arb%0d_rd_en", idx), reg_rd_en, 1);
      check($sformatf("arb%0d_addr", idx), reg_addr, 32'h200 + 32'(idx * 4));
    end else begin
      check($sformatf("arb%0d_wr_en", idx), reg_wr_en, 1);
      check($sformatf("arb%0d_addr", idx), reg_addr, 32'h100 + 32'(idx * 4));
    end
    step();
    reg_ack = 1'b0; reg_rd_data = 32'hDEAD;
    if (exp_rd) begin
      for (int k = 0; k < 10; k++) begin
        mid();
        check($sformatf("arb%0d_hold_rvalid", idx), rvalid, 1);
        check($sformatf("arb%0d_hold_rdata", idx), rdata, 32'hA0 + 32'(idx));
        step();
      end
      rready = 1'b1;
      mid();
      check($sformatf("arb%0d_rresp", idx), {rvalid, rresp}, 3'b100);
      step();
      rready = 1'b0;
    end else begin
      bready = 1'b1;
      mid();
      check($sformatf("arb%0d_bresp", idx), {bvalid, bresp}, 3'b100);
      step();
      bready = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    reg_rd_data = '0; reg_ack = 1'b0;

    // Reset state
    repeat (3) step();
    mid();
    check("rst_ready", {awready, wready, arready}, 3'b000);
    check("rst_valid", {bvalid, rvalid}, 2'b00);
    check("rst_strobe", {reg_wr_en, reg_rd_en}, 2'b00);
    check("rst_rdata", rdata, 0);
    check("rst_regaddr", reg_addr, 0);
    step();
    rst = 1'b0;
    mid();
    check("idle_ready", {awready, wready, arready}, 3'b111);

    // Write 0x10, ack one cycle after strobe
    step();
    awvalid = 1'b1; awaddr = 32'h10; wvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    wr0 = n_wr_pulse;
    mid();
    check("t1_aw_w_ready", {awready, wready}, 2'b11);
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    mid();
    check("t1_strobe", reg_wr_en, 1);
    check("t1_addr", reg_addr, 32'h10);
    check("t1_data", reg_wr_data, 32'hDEADBEEF);
    check("t1_strb", reg_wr_strb, 4'hF);
    check("t1_no_early_b", bvalid, 0);
    step();
    reg_ack = 1'b1;
    mid();
    check("t1_strobe_once", reg_wr_en, 0);
    check("t1_b_not_yet", bvalid, 0);
    step();
    reg_ack = 1'b0; bready = 1'b1;
    mid();
    check("t1_bvalid", {bvalid, bresp}, 3'b100);
    check("t1_busy_awready", awready, 0);
    check("t1_held_data", reg_wr_data, 32'hDEADBEEF);
    step();
    bready = 1'b0;
    mid();
    check("t1_b_done", bvalid, 0);
    check("t1_accept_next", awready, 1);
    check("t1_pulses", n_wr_pulse - wr0, 1);

    // W five cycles before AW
    step();
    wvalid = 1'b1; wdata = 32'hCAFEF00D; wstrb = 4'h3;
    wr0 = n_wr_pulse;
    mid();
    check("t2_wready", wready, 1);
    step();
    wvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mid();
      check("t2_no_early_strobe", reg_wr_en, 0);
      check("t2_w_held", {wready, awready, arready}, 3'b010);
      step();
    end
    awvalid = 1'b1; awaddr = 32'h44;
    mid();
    check("t2_awready", awready, 1);
    step();
    awvalid = 1'b0; reg_ack = 1'b1;
    mid();
    check("t2_strobe", reg_wr_en, 1);
    check("t2_addr", reg_addr, 32'h44);
    check("t2_data", reg_wr_data, 32'hCAFEF00D);
    check("t2_strb", reg_wr_strb, 4'h3);
    step();
    reg_ack = 1'b0; bready = 1'b1;
    mid();
    check("t2_bvalid", {bvalid, bresp}, 3'b100);
    step();
    bready = 1'b0;
    mid();
    check("t2_pulses", n_wr_pulse - wr0, 1);

    // Round-robin arbitration, read has priority at this point
    arb_round(0, 1'b1);
    arb_round(1, 1'b0);
    arb_round(2, 1'b1);
    arb_round(3, 1'b0);

    // Read 0x20, ack in the strobe cycle
    step();
    arvalid = 1'b1; araddr = 32'h20;
    mid();
    check("t3_arready", arready, 1);
    step();
    arvalid = 1'b0; reg_ack = 1'b1; reg_rd_data = 32'h12345678;
    mid();
    check("t3_strobe", reg_rd_en, 1);
    check("t3_addr", reg_addr, 32'h20);
    check("t3_r_not_yet", rvalid, 0);
    step();
    reg_ack = 1'b0; reg_rd_data = 32'hFFFFFFFF; rready = 1'b1;
    mid();
    check("t3_rvalid", {rvalid, rresp}, 3'b100);
    check("t3_rdata", rdata, 32'h12345678);
    step();
    rready = 1'b0;
    mid();
    check("t3_r_done", rvalid, 0);

    // Timeout: no ack
    step();
    arvalid = 1'b1; araddr = 32'h30;
    step();
    arvalid = 1'b0;
    mid();
    check("t4_strobe", reg_rd_en, 1);
    for (int k = 1; k < 16; k++) begin
      step();
      mid();
      check("t4_wait_rvalid", rvalid, 0);
    end
    step();
    mid();
    check("t4_rvalid", {rvalid, rresp}, 3'b110);
    check("t4_rdata", rdata, 0);
    step();
    reg_ack = 1'b1; reg_rd_data = 32'h55555555;
    mid();
    check("t4_late_ack_resp", {rvalid, rresp}, 3'b110);
    check("t4_late_ack_data", rdata, 0);
    step();
    reg_ack = 1'b0; rready = 1'b1;
    step();
    rready = 1'b0; reg_ack = 1'b1;
    mid();
    check("t4_idle_ack_valid", {bvalid, rvalid}, 2'b00);
    step();
    reg_ack = 1'b0;
    mid();
    check("t4_idle_ack_after", {bvalid, rvalid, reg_rd_en, reg_wr_en}, 4'b0000);

    // Reset during RD_WAIT
    step();
    arvalid = 1'b1; araddr = 32'h50;
    step();
    arvalid = 1'b0;
    mid();
    check("t6_strobe", reg_rd_en, 1);
    step();
    rst = 1'b1;
    mid();
    check("t6_rst_ready", {awready, wready, arready}, 3'b000);
    step();
    reg_ack = 1'b1; reg_rd_data = 32'h77777777;
    mid();
    check("t6_rst_valid", {bvalid, rvalid, reg_rd_en, reg_wr_en}, 4'b0000);
    check("t6_rst_addr", reg_addr, 0);
    check("t6_rst_rdata", rdata, 0);
    step();
    rst = 1'b0; reg_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mid();
      check("t6_no_rvalid", rvalid, 0);
      step();
    end
    arvalid = 1'b1; araddr = 32'h54;
    mid();
    check("t6_arready", arready, 1);
    step();
    arvalid = 1'b0; reg_ack = 1'b1; reg_rd_data = 32'h0BADF00D;
    mid();
    check("t6_addr", reg_addr, 32'h54);
    step();
    reg_ack = 1'b0; rready = 1'b1;
    mid();
    check("t6_rvalid", {rvalid, rresp}, 3'b100);
    check("t6_rdata", rdata, 32'h0BADF00D);
    step();
    rready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
